tx_symbol_scheduler: RTL

Sequences the 8b/10b TX encoder input, one symbol per BitCLK_10 cycle. Brings the link up with a comma alignment burst, then frames packets as SOF / data / EOF. Fills gaps with idle commas and inserts periodic clock-compensation skip symbols. Sits between the packet source (valid/ready stream) and the encoder's TxParallel_8/TxDataK inputs.

---
 rtl/tx_symbol_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tx_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_symbol_scheduler
// Function : Symbol sequencer for the 8b/10b TX path. It handles alignment,
//            SOF/data/EOF framing, idle fill and periodic skip insertion.
// Revision : 1.0 - initial release
// ============================================================================
module tx_symbol_scheduler #(
    parameter int ALIGN_COUNT   = 16,
    parameter int SKIP_INTERVAL = 64,
    parameter int UNDERRUN_W    = 8
) (
    input  logic                  BitCLK_10,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [7:0]            TxParallel_8,
    output logic                  TxDataK,
    output logic                  link_up,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    localparam int AW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
    localparam int SW = $clog2(SKIP_INTERVAL);

    localparam logic [AW-1:0] c_ALIGN_LAST = AW'(ALIGN_COUNT - 1);
    localparam logic [AW-1:0] c_ALIGN_ONE  = AW'(1);
    localparam logic [SW-1:0] c_SKIP_LAST  = SW'(SKIP_INTERVAL - 1);
    localparam logic [SW-1:0] c_SYM_ONE    = SW'(1);
    localparam logic [UNDERRUN_W-1:0] c_UND_ONE = UNDERRUN_W'(1);

    localparam logic [7:0] c_K28_5 = 8'hBC;
    localparam logic [7:0] c_K27_7 = 8'hFB;
    localparam logic [7:0] c_K29_7 = 8'hFD;
    localparam logic [7:0] c_K28_0 = 8'h1C;
    localparam logic [7:0] c_K23_7 = 8'hF7;

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DATA  = 2'd2,
        ST_EOF   = 2'd3
    } state_t;

    state_t                r_state;
    logic [AW-1:0]         r_align_cnt;
    logic [SW-1:0]         r_sym_cnt;
    logic [7:0]            r_tx_byte;
    logic                  r_tx_k;
    logic                  r_link_up;
    logic [UNDERRUN_W-1:0] r_underrun;

    logic                  w_skip_due;
    logic [SW-1:0]         w_sym_inc;

    assign w_skip_due = r_link_up & (r_sym_cnt == c_SKIP_LAST);
    // Saturating so a skip deferred by EOF is still pending in the next IDLE cycle
    assign w_sym_inc  = (r_sym_cnt == c_SKIP_LAST) ? r_sym_cnt : r_sym_cnt + c_SYM_ONE;

    assign s_ready      = (r_state == ST_DATA) & Enable & ~w_skip_due;
    assign TxParallel_8 = r_tx_byte;
    assign TxDataK      = r_tx_k;
    assign link_up      = r_link_up;
    assign underrun_cnt = r_underrun;

    always_ff @(posedge BitCLK_10 or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_ALIGN;
            r_align_cnt <= '0;
            r_sym_cnt   <= '0;
            r_tx_byte   <= c_K28_5;
            r_tx_k      <= 1'b1;
            r_link_up   <= 1'b0;
            r_underrun  <= '0;
        end else if ((r_state != ST_ALIGN) && !Enable) begin
            // Dropping Enable abandons any open packet without an EOF
            r_state     <= ST_ALIGN;
            r_align_cnt <= '0;
            r_sym_cnt   <= '0;
            r_tx_byte   <= c_K28_5;
            r_tx_k      <= 1'b1;
            r_link_up   <= 1'b0;
        end else begin
            case (r_state)
                ST_ALIGN: begin
                    r_tx_byte <= c_K28_5;
                    r_tx_k    <= 1'b1;
                    r_sym_cnt <= '0;
                    if (!Enable) begin
                        r_align_cnt <= '0;
                    end else if (r_align_cnt == c_ALIGN_LAST) begin
                        r_align_cnt <= '0;
                        r_link_up   <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_align_cnt <= r_align_cnt + c_ALIGN_ONE;
                    end
                end
                ST_IDLE: begin
                    r_tx_k <= 1'b1;
                    if (w_skip_due) begin
                        r_tx_byte <= c_K28_0;
                        r_sym_cnt <= '0;
                    end else if (s_valid) begin
                        r_tx_byte <= c_K27_7;
                        r_sym_cnt <= w_sym_inc;
                        r_state   <= ST_DATA;
                    end else begin
                        r_tx_byte <= c_K28_5;
                        r_sym_cnt <= w_sym_inc;
                    end
                end
                ST_DATA: begin
                    if (w_skip_due) begin
                        r_tx_byte <= c_K28_0;
                        r_tx_k    <= 1'b1;
                        r_sym_cnt <= '0;
                    end else if (s_valid) begin
                        r_tx_byte <= s_data;
                        r_tx_k    <= 1'b0;
                        r_sym_cnt <= w_sym_inc;
                        if (s_last) begin
                            r_state <= ST_EOF;
                        end
                    end else begin
                        r_tx_byte <= c_K23_7;
                        r_tx_k    <= 1'b1;
                        r_sym_cnt <= w_sym_inc;
                        if (r_underrun != '1) begin
                            r_underrun <= r_underrun + c_UND_ONE;
                        end
                    end
                end
                ST_EOF: begin
                    r_tx_byte <= c_K29_7;
                    r_tx_k    <= 1'b1;
                    r_sym_cnt <= w_sym_inc;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_ALIGN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
